// File: rtl/team_06_sample_fifo.sv
// team_06_sample_fifo
//   Captures one sample per rising edge of the ADC-to-I2S deserializer's
//   finished flag, tagged with its channel (ws). Samples are buffered in a
//   DEPTH-entry FIFO and presented on a valid/ready stream.
//
//   Optional feature: define LEVEL_PEAK_EN to track per-channel peak
//   magnitudes. Without it, peak_l/peak_r are tied to 0.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   sample_in[8:0]   magnitude; only [7:0] is stored
//   finished         word-complete level flag; a rising edge is one capture
//   ws               channel of the sample (0 = left, 1 = right)
//   clear            synchronous flush of FIFO, overflow and peaks
//   out_data[8:0]    {channel, magnitude} at the FIFO head (0 when empty)
//   out_valid        head entry is valid
//   out_ready        consumer accepts the head this cycle
//   fill_level       entries stored, 0..DEPTH
//   full, empty      fill_level == DEPTH / == 0
//   overflow         sticky: a capture was dropped because the FIFO was full
//   peak_l, peak_r   per-channel peak magnitude
module team_06_sample_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [8:0]    sample_in,
  input  logic          finished,
  input  logic          ws,
  input  logic          clear,
  output logic [8:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   fill_level,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic [7:0]    peak_l,
  output logic [7:0]    peak_r
);

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic          r_fin_q;
  logic          r_ovf;

  logic w_push_req;
  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_wr_en;

  assign w_push_req = finished & ~r_fin_q;
  assign w_valid    = (r_cnt != '0);
  assign w_full     = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop      = w_valid & out_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO still
  // accepts the push (the write lands on the slot being vacated).
  assign w_wr_en    = w_push_req & (~w_full | w_pop);

  // Storage has no reset; entries are only observed through r_cnt.
  always_ff @(posedge clk) begin
    if (!rst && !clear && w_wr_en)
      r_mem[r_wr_ptr] <= {ws, sample_in[7:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_fin_q  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_fin_q <= finished;
      if (clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
        r_ovf    <= 1'b0;
      end else begin
        if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_wr_en, w_pop})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
        if (w_push_req && !w_wr_en) r_ovf <= 1'b1;
      end
    end
  end

  assign out_valid  = w_valid;
  assign out_data   = w_valid ? r_mem[r_rd_ptr] : 9'd0;
  assign fill_level = r_cnt;
  assign full       = w_full;
  assign empty      = ~w_valid;
  assign overflow   = r_ovf;

`ifdef LEVEL_PEAK_EN
  logic [7:0] r_peak_l;
  logic [7:0] r_peak_r;

  // Only accepted pushes count; dropped samples never reach the stream.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_peak_l <= '0;
      r_peak_r <= '0;
    end else if (w_wr_en) begin
      if (!ws && sample_in[7:0] > r_peak_l) r_peak_l <= sample_in[7:0];
      if ( ws && sample_in[7:0] > r_peak_r) r_peak_r <= sample_in[7:0];
    end
  end

  assign peak_l = r_peak_l;
  assign peak_r = r_peak_r;
`else
  assign peak_l = 8'd0;
  assign peak_r = 8'd0;
`endif

endmodule

// File: tb/tb_team_06_sample_fifo.sv
// Bench for team_06_sample_fifo: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_team_06_sample_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst, finished, ws, clear, out_ready;
  logic [8:0]    sample_in;
  logic [8:0]    out_data;
  logic          out_valid, full, empty, overflow;
  logic [AW:0]   fill_level;
  logic [7:0]    peak_l, peak_r;

  team_06_sample_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .finished(finished), .ws(ws),
    .clear(clear), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fill_level(fill_level), .full(full), .empty(empty), .overflow(overflow),
    .peak_l(peak_l), .peak_r(peak_r)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // Reference model: plain queue of {ws, magnitude} entries.
  logic [8:0] m_q[$];
  bit         m_fin_q;
  bit         m_ovf;
  int         m_pk_l, m_pk_r;

  task automatic model_edge();
    bit push, pop, room;
    int mag;
    if (rst) begin
      m_q.delete(); m_fin_q = 0; m_ovf = 0; m_pk_l = 0; m_pk_r = 0;
      return;
    end
    push = finished && !m_fin_q;
    m_fin_q = finished;
    if (clear) begin
      m_q.delete(); m_ovf = 0; m_pk_l = 0; m_pk_r = 0;
      return;
    end
    pop  = (m_q.size() > 0) && out_ready;
    room = (m_q.size() < DEPTH) || pop;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (room) begin
        m_q.push_back({ws, sample_in[7:0]});
        mag = int'(sample_in[7:0]);
`ifdef LEVEL_PEAK_EN
        if (!ws && mag > m_pk_l) m_pk_l = mag;
        if ( ws && mag > m_pk_r) m_pk_r = mag;
`endif
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic check_all();
    int sz;
    sz = m_q.size();
    chk("fill_level", int'(fill_level), sz);
    chk("full",       int'(full),       int'(sz == DEPTH));
    chk("empty",      int'(empty),      int'(sz == 0));
    chk("out_valid",  int'(out_valid),  int'(sz != 0));
    chk("out_data",   int'(out_data),   (sz != 0) ? int'(m_q[0]) : 0);
    chk("overflow",   int'(overflow),   int'(m_ovf));
    chk("peak_l",     int'(peak_l),     m_pk_l);
    chk("peak_r",     int'(peak_r),     m_pk_r);
  endtask

  // One clock: inputs are already set; model tracks the edge, check after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    rst = 0; finished = 0; ws = 0; clear = 0; out_ready = 0; sample_in = '0;
  endtask

  // One capture: finished high for 'hold' cycles, then low for one.
  task automatic cap(input logic [8:0] v, input logic w, input logic rdy, input int hold);
    sample_in = v; ws = w; out_ready = rdy; finished = 1;
    for (int i = 0; i < hold; i++) step();
    finished = 0;
    step();
  endtask

  initial begin
    int thr;
    idle_inputs();
    rst = 1;
    step(); step();
    rst = 0;
    step(); step();
    chk("rst_empty", int'(empty), 1);
    chk("rst_fill",  int'(fill_level), 0);
    chk("rst_ovf",   int'(overflow), 0);

    // Held finished: single capture, visible next cycle.
    sample_in = 9'h0A5; ws = 1; finished = 1;
    step();
    chk("hold_valid", int'(out_valid), 1);
    chk("hold_data",  int'(out_data), 'h1A5);
    for (int i = 0; i < 4; i++) step();
    finished = 0; step();
    chk("hold_fill", int'(fill_level), 1);

    clear = 1; step(); clear = 0; step();

    // 17 captures into a DEPTH-16 FIFO.
    for (int v = 1; v <= 17; v++) begin
      cap(9'(v), 1'b0, 1'b0, 1);
      if (v == 16) chk("full16", int'(full), 1);
      if (v == 16) chk("ovf16",  int'(overflow), 0);
    end
    chk("ovf17", int'(overflow), 1);
    out_ready = 1;
    for (int v = 1; v <= 16; v++) begin
      chk("drain", int'(out_data), v);
      step();
    end
    chk("drain_empty", int'(empty), 1);
    chk("ovf_sticky",  int'(overflow), 1);
    out_ready = 0;

    // Full with simultaneous push and pop.
    clear = 1; step(); clear = 0;
    for (int v = 1; v <= 16; v++) cap(9'(v + 32), 1'b1, 1'b0, 1);
    cap(9'h0EE, 1'b0, 1'b1, 1);
    out_ready = 0; step();
    chk("pp_fill", int'(fill_level), DEPTH - 1);
    chk("pp_ovf",  int'(overflow), 0);
    out_ready = 1;
    while (m_q.size() > 1) step();
    chk("pp_last", int'(out_data), 'h0EE);
    step();
    out_ready = 0;

    // Clear with simultaneous push_req.
    for (int v = 0; v < 3; v++) cap(9'(v + 100), 1'b0, 1'b0, 1);
    sample_in = 9'h077; finished = 1; clear = 1;
    step();
    clear = 0; finished = 0;
    chk("clr_empty", int'(empty), 1);
    chk("clr_valid", int'(out_valid), 0);
    chk("clr_fill",  int'(fill_level), 0);
    step();
    chk("clr_nopush", int'(fill_level), 0);

    // Peak tracking.
    cap(9'd40, 0, 0, 1); cap(9'd200, 0, 0, 1); cap(9'd90, 0, 0, 1);
    cap(9'd255, 1, 0, 2); cap(9'd10, 1, 0, 1);
`ifdef LEVEL_PEAK_EN
    chk("peak_l_val", int'(peak_l), 200);
    chk("peak_r_val", int'(peak_r), 255);
`else
    chk("peak_l_off", int'(peak_l), 0);
    chk("peak_r_off", int'(peak_r), 0);
`endif
    clear = 1; step(); clear = 0; step();
    chk("peak_l_clr", int'(peak_l), 0);
    chk("peak_r_clr", int'(peak_r), 0);

    // Reset mid-stream.
    for (int v = 0; v < 5; v++) cap(9'(v + 7), 1'b1, 1'b0, 1);
    rst = 1; step(); rst = 0; step();
    chk("rst_mid_fill", int'(fill_level), 0);

    // Randomized traffic with phases of varying consumer throughput.
    for (int blk = 0; blk < 6; blk++) begin
      thr = (blk % 3 == 0) ? 10 : (blk % 3 == 1) ? 50 : 90;
      for (int i = 0; i < 400; i++) begin
        sample_in = 9'($urandom);
        ws        = 1'($urandom);
        finished  = ($urandom_range(0, 99) < 45);
        out_ready = ($urandom_range(0, 99) < thr);
        clear     = ($urandom_range(0, 99) == 0);
        rst       = ($urandom_range(0, 299) == 0);
        step();
      end
    end
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
